// File: rtl/wm_pkg.sv
// wm_pkg: shared types for the wash-cycle controller.
//   wm_state_t    - 4-bit state code, IDLE = 0 (also exported on the debug port)
//   wm_act_t      - actuator drive bundle
//   WM_ACT_DECODE - Moore output decode, indexed by state code
//   is_phase      - states that run a timed phase and may be paused by the door
//   uses_timer    - states whose duration comes from the phase timer
package wm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_FILL        = 4'd1,
        ST_WASH        = 4'd2,
        ST_RINSE       = 4'd3,
        ST_DRAIN       = 4'd4,
        ST_SPIN        = 4'd5,
        ST_HOLD        = 4'd6,
        ST_ABORT_DRAIN = 4'd7,
        ST_DONE        = 4'd8
    } wm_state_t;

    // Field order matters for the decode table below.
    typedef struct packed {
        logic water_fill;
        logic agitator;
        logic motor;
        logic pump;
        logic speed;
        logic door_lock;
    } wm_act_t;

    // Bits: water_fill, agitator, motor, pump, speed, door_lock.
    // Unused codes decode to everything off.
    localparam wm_act_t WM_ACT_DECODE [0:15] = '{
        6'b000000,  // IDLE
        6'b100001,  // FILL
        6'b011001,  // WASH
        6'b011001,  // RINSE
        6'b000101,  // DRAIN
        6'b001011,  // SPIN
        6'b000000,  // HOLD: door may be open, so everything is released
        6'b000101,  // ABORT_DRAIN
        6'b000000,  // DONE
        6'b000000,
        6'b000000,
        6'b000000,
        6'b000000,
        6'b000000,
        6'b000000,
        6'b000000
    };

    function automatic logic is_phase(input wm_state_t s);
        return (s == ST_FILL) || (s == ST_WASH) || (s == ST_RINSE) ||
               (s == ST_DRAIN) || (s == ST_SPIN);
    endfunction

    function automatic logic uses_timer(input wm_state_t s);
        return is_phase(s) || (s == ST_ABORT_DRAIN);
    endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// wm_phase_timer: phase down-counter.
//   clk, rst  - clock, asynchronous active-high reset (count -> 0)
//   load      - load load_val (takes priority over en)
//   load_val  - DUR-1 of the phase being entered
//   en        - count down by one; holds at zero
//   count     - current remaining count
//   expired   - count is zero (the current cycle is the phase's last)
module wm_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/wm_cycle_controller.sv
// wm_cycle_controller: wash-cycle sequencer with internal phase timers,
// programmable rinse passes, door pause/resume and an abort drain.
//   clk, rst     - clock, asynchronous active-high reset
//   start        - level; starts a cycle when sampled high in IDLE
//   abort        - level; cancels a running cycle through ABORT_DRAIN
//   door         - 1 = door open; pauses a running phase into HOLD
//   rinse_count  - rinse passes after wash, latched at start
//   water_fill, agitator, motor, pump, speed - actuator drives
//   door_lock    - door interlock solenoid
//   busy         - state is not IDLE
//   done         - one-cycle pulse on normal completion (DONE state)
//   state        - current state code for debug
module wm_cycle_controller
    import wm_pkg::*;
#(
    parameter int FILL_CYC  = 8,
    parameter int WASH_CYC  = 16,
    parameter int RINSE_CYC = 12,
    parameter int DRAIN_CYC = 6,
    parameter int SPIN_CYC  = 10,
    parameter int CNT_W     = 16,
    parameter int RINSE_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               door,
    input  logic [RINSE_W-1:0] rinse_count,
    output logic               water_fill,
    output logic               agitator,
    output logic               motor,
    output logic               pump,
    output logic               speed,
    output logic               door_lock,
    output logic               busy,
    output logic               done,
    output logic [3:0]         state
);

    wm_state_t          state_q;
    wm_state_t          state_d;
    wm_state_t          saved_q;     // phase to return to after HOLD
    logic [RINSE_W-1:0] rinse_left_q;
    logic               wash_done_q; // distinguishes first FILL from rinse FILLs

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_load_val;
    logic               tmr_en;
    logic [CNT_W-1:0]   tmr_count;
    logic               tmr_expired;
    logic               resuming;
    wm_act_t            act;

    // ------------------------------------------------------------------
    // State register and per-cycle bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            saved_q      <= ST_IDLE;
            rinse_left_q <= '0;
            wash_done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && state_d == ST_FILL) begin
                rinse_left_q <= rinse_count;
                wash_done_q  <= 1'b0;
            end
            if (state_q == ST_WASH && state_d == ST_DRAIN) begin
                wash_done_q <= 1'b1;
            end
            if (state_q == ST_DRAIN && state_d == ST_FILL) begin
                rinse_left_q <= rinse_left_q - 1'b1;
            end
            if (is_phase(state_q) && state_d == ST_HOLD) begin
                saved_q <= state_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority: abort > door > timer expiry.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FILL;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ABORT_DRAIN: begin
                // door is deliberately ignored while draining after abort
                if (tmr_expired) state_d = ST_IDLE;
            end
            ST_HOLD: begin
                if (abort)      state_d = ST_ABORT_DRAIN;
                else if (!door) state_d = saved_q;
            end
            ST_FILL, ST_WASH, ST_RINSE, ST_DRAIN, ST_SPIN: begin
                if (abort) begin
                    state_d = ST_ABORT_DRAIN;
                end else if (door) begin
                    state_d = ST_HOLD;
                end else if (tmr_expired) begin
                    case (state_q)
                        ST_FILL:  state_d = wash_done_q ? ST_RINSE : ST_WASH;
                        ST_WASH:  state_d = ST_DRAIN;
                        ST_RINSE: state_d = ST_DRAIN;
                        ST_DRAIN: state_d = (rinse_left_q == '0) ? ST_SPIN : ST_FILL;
                        default:  state_d = ST_DONE;  // ST_SPIN
                    endcase
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Phase timer control. A fresh duration is loaded on entry to any timed
    // state, except when returning from HOLD where the paused count is kept.
    // ------------------------------------------------------------------
    assign resuming = (state_q == ST_HOLD) && (state_d == saved_q);
    assign tmr_load = uses_timer(state_d) && (state_d != state_q) && !resuming;
    assign tmr_en   = uses_timer(state_q);

    always_comb begin
        tmr_load_val = '0;
        case (state_d)
            ST_FILL:        tmr_load_val = CNT_W'(FILL_CYC - 1);
            ST_WASH:        tmr_load_val = CNT_W'(WASH_CYC - 1);
            ST_RINSE:       tmr_load_val = CNT_W'(RINSE_CYC - 1);
            ST_DRAIN:       tmr_load_val = CNT_W'(DRAIN_CYC - 1);
            ST_ABORT_DRAIN: tmr_load_val = CNT_W'(DRAIN_CYC - 1);
            ST_SPIN:        tmr_load_val = CNT_W'(SPIN_CYC - 1);
            default:        tmr_load_val = '0;
        endcase
    end

    wm_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .count    (tmr_count),
        .expired  (tmr_expired)
    );

    // ------------------------------------------------------------------
    // Moore outputs decoded from the state register only
    // ------------------------------------------------------------------
    always_comb begin
        act        = WM_ACT_DECODE[state_q];
        water_fill = act.water_fill;
        agitator   = act.agitator;
        motor      = act.motor;
        pump       = act.pump;
        speed      = act.speed;
        door_lock  = act.door_lock;
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        state      = state_q;
    end

endmodule

// File: doc/wm_cycle_controller.md
# wm_cycle_controller

Parametrised wash-cycle sequencer, the next generation of the appliance control FSM. It replaces the external phase-done strobes with internal phase timers, runs a programmable number of rinse passes, and lets the door pause any running phase and resume it. It also adds an abort path that always drains the drum before returning to idle. It sits between the front-panel logic (start/abort/rinse selection), the door sensor and the actuator drivers.

## Interface
- FILL_CYC, 8: fill phase duration in clk cycles (≥1)
- WASH_CYC, 16: wash phase duration (≥1)
- RINSE_CYC, 12: rinse agitation duration (≥1)
- DRAIN_CYC, 6: drain duration, also used for abort drain (≥1)
- SPIN_CYC, 10: spin duration (≥1)
- CNT_W, 16: phase timer width; every *_CYC ≤ 2^CNT_W
- RINSE_W, 2: width of rinse count
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; begins a cycle when sampled high in IDLE
- abort  in  1  level; cancels a running cycle
- door  in  1  1 = door open
- rinse_count  in  RINSE_W  rinse passes after wash, latched at start
- water_fill, agitator, motor, pump, speed  out  1 each  actuator drives
- door_lock  out  1  door interlock solenoid
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on normal completion
- state  out  4  current state code, for debug

## Operation
- States: IDLE, FILL, WASH, RINSE, DRAIN, SPIN, HOLD, ABORT_DRAIN, DONE.
- IDLE & start: latch rinse_count into rinse_left, clear wash_done, go to FILL.
- FILL expires: go to WASH if !wash_done, else to RINSE.
- WASH expires: set wash_done, go to DRAIN.
- RINSE expires: go to DRAIN.
- DRAIN expires: if rinse_left = 0 go to SPIN; else decrement rinse_left and go to FILL.
- SPIN expires: go to DONE. DONE goes to IDLE unconditionally after 1 cycle.
- Door: door=1 in FILL/WASH/RINSE/DRAIN/SPIN saves the state, freezes the timer and enters HOLD. In HOLD, door=0 returns to the saved state with the remaining count intact.
- Abort: abort=1 in any state except IDLE/DONE/ABORT_DRAIN enters ABORT_DRAIN, which runs for DRAIN_CYC and then goes to IDLE. done is not pulsed on this path. Door is ignored in ABORT_DRAIN.
- Priority within a cycle: abort > door > timer expiry.
- start is ignored outside IDLE. start still high on DONE→IDLE starts a new cycle on the next edge.
- Outputs are Moore, decoded from the state register:
  - FILL: water_fill.
  - WASH, RINSE: agitator + motor.
  - DRAIN, ABORT_DRAIN: pump.
  - SPIN: motor + speed.
  - HOLD, IDLE, DONE: all actuators 0.
- door_lock = 1 in FILL, WASH, RINSE, DRAIN, SPIN, ABORT_DRAIN; 0 in IDLE, HOLD, DONE.

## Timing
- Reset: state = IDLE, timer = 0, rinse_left = 0, wash_done = 0. Every output is 0.
- rst mid-cycle returns to IDLE immediately (asynchronous); no drain is performed.
- Phase timer:
  - On entry to a timed state, load DUR−1.
  - Decrement each cycle while not in HOLD.
  - Expiry = (count = 0) in a timed state; the transition happens on that edge.
- Each phase therefore occupies exactly DUR cycles. HOLD adds its own duration; the HOLD exit cycle does not decrement.
- Start latency: start sampled at edge N puts FILL in the cycle after N.
- rinse_count changes after start have no effect on the running cycle.
- rinse_count = 0: sequence is FILL, WASH, DRAIN, SPIN.

## Structure
- Shared package wm_pkg holds:
  - the state enum (4-bit encoding, IDLE = 0);
  - the actuator output bundle type;
  - the per-state output decode constant.
- Sub-module wm_phase_timer: CNT_W down-counter with load, load value, enable and expired outputs.

## Test plan
- Defaults, rinse_count=1, start pulse, door=0 → phases FILL 8, WASH 16, DRAIN 6, FILL 8, RINSE 12, DRAIN 6, SPIN 10. done is high exactly at cycle 66 after FILL entry; busy falls the following cycle.
- rinse_count=0 → FILL/WASH/DRAIN/SPIN only. done at cycle 40. No RINSE state is ever visited.
- door=1 for 5 cycles at WASH cycle 4 → HOLD with all actuators 0 and door_lock 0. WASH resumes with 12 cycles remaining; total completion is delayed by exactly 5 cycles.
- abort in SPIN cycle 3 → ABORT_DRAIN with only pump=1 for 6 cycles, then IDLE. done stays 0.
- rst asserted in RINSE → all outputs 0 asynchronously, state=0. A start after release begins at FILL with a fresh rinse_count.
- Simultaneous events:
  - abort and door=1 on the FILL expiry cycle → ABORT_DRAIN.
  - start held high through DONE → second cycle begins; done pulses once per cycle.
